// File: rtl/risc_mc_core_if.sv
// Memory-side bus of risc_mc_core: instruction fetch port and data port.
// Both ports use the same req/ready handshake. A transfer completes on
// any cycle where req and ready are both high. The requester holds req and
// every request field (addr, we, wdata) stable until that cycle. Ready may
// rise in the same cycle as req (zero wait) and is ignored while req is low.
// Read data (imem_data, dmem_rdata) is sampled in the completing cycle.
interface risc_mc_core_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 4,
    parameter int PC_W   = 6
);
    localparam int INSTR_W = 5 + 3 * REG_AW;

    // Instruction fetch port
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_data;

    // Data load/store port
    logic               dmem_req;
    logic               dmem_we;
    logic [DATA_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_ready;
    logic [DATA_W-1:0]  dmem_rdata;

    // Core side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data,
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    // Memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data,
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/risc_mc_core.sv
// risc_mc_core: multicycle RISC core (PC, register file, ALU, controller).
// Instruction flow: FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK, with an
// absorbing HALT state. R0 is hardwired to zero. dbg_state exposes the FSM.
// Optional feature macro: RISC_MC_ILLEGAL_TRAP_EN -- when defined, an
// undefined opcode halts the core and raises the trap output; otherwise
// undefined opcodes execute as NOPs.
module risc_mc_core #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 4,
    parameter int PC_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    risc_mc_core_if.master       bus,
    output logic                 halted,
    input  logic [REG_AW-1:0]    dbg_sel,
    output logic [DATA_W-1:0]    dbg_data,
    output logic [2:0]           dbg_state
`ifdef RISC_MC_ILLEGAL_TRAP_EN
    ,
    output logic                 trap
`endif
);

    localparam int INSTR_W = 5 + 3 * REG_AW;
    localparam int IMM_W   = 2 * REG_AW;
    localparam int NREGS   = 2 ** REG_AW;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_LDI  = 5'd6;
    localparam logic [4:0] OP_LD   = 5'd7;
    localparam logic [4:0] OP_ST   = 5'd8;
    localparam logic [4:0] OP_BEQZ = 5'd9;
    localparam logic [4:0] OP_JMP  = 5'd10;
    localparam logic [4:0] OP_HALT = 5'd31;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // Architectural state
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   regs [NREGS];

    // Pipeline-style holding registers between the multicycle steps
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   op_a;        // R[rs1]
    logic [DATA_W-1:0]   op_b;        // R[rs2]
    logic [DATA_W-1:0]   op_d;        // R[rd]
    logic [DATA_W-1:0]   res_q;       // ALU result, replaced by load data
    logic [PC_W-1:0]     npc_q;
    logic                wb_en_q;
    logic [DATA_W-1:0]   maddr_q;
    logic [DATA_W-1:0]   mwdata_q;
    logic                mwe_q;

    // Instruction fields
    logic [4:0]          opcode;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   imm_data;
    logic [PC_W-1:0]     imm_pc;

    // EXECUTE-step combinational results
    logic [DATA_W-1:0]   exe_res;
    logic [PC_W-1:0]     exe_npc;
    logic                exe_wb;
    logic                exe_mem;
    logic                exe_we;
    logic                exe_halt;
`ifdef RISC_MC_ILLEGAL_TRAP_EN
    logic                exe_illegal;
    logic                trap_q;
`endif

    // FSM outputs before reset gating
    logic                imem_req_c;
    logic                dmem_req_c;

    assign opcode   = ir[INSTR_W-1 -: 5];
    assign rd       = ir[3*REG_AW-1 -: REG_AW];
    assign rs1      = ir[2*REG_AW-1 -: REG_AW];
    assign rs2      = ir[REG_AW-1:0];
    assign imm      = ir[IMM_W-1:0];
    // Data immediates are zero-extended, branch immediates sign-extended;
    // both truncate when the target is narrower.
    assign imm_data = DATA_W'(imm);
    assign imm_pc   = PC_W'($signed(imm));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and request strobes
    always_comb begin
        state_nxt  = state;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (exe_halt) begin
                    state_nxt = S_HALT;
`ifdef RISC_MC_ILLEGAL_TRAP_EN
                end else if (exe_illegal) begin
                    state_nxt = S_HALT;
`endif
                end else if (exe_mem) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WRITEBACK;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                if (bus.dmem_ready) begin
                    state_nxt = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Opcode decode and ALU for the EXECUTE step
    always_comb begin
        exe_res  = '0;
        exe_npc  = pc + PC_W'(1);
        exe_wb   = 1'b0;
        exe_mem  = 1'b0;
        exe_we   = 1'b0;
        exe_halt = 1'b0;
`ifdef RISC_MC_ILLEGAL_TRAP_EN
        exe_illegal = 1'b0;
`endif
        case (opcode)
            OP_ADD:  begin exe_res = op_a + op_b;     exe_wb = 1'b1; end
            OP_SUB:  begin exe_res = op_a - op_b;     exe_wb = 1'b1; end
            OP_AND:  begin exe_res = op_a & op_b;     exe_wb = 1'b1; end
            OP_OR:   begin exe_res = op_a | op_b;     exe_wb = 1'b1; end
            OP_XOR:  begin exe_res = op_a ^ op_b;     exe_wb = 1'b1; end
            OP_ADDI: begin exe_res = op_d + imm_data; exe_wb = 1'b1; end
            OP_LDI:  begin exe_res = imm_data;        exe_wb = 1'b1; end
            OP_LD:   begin exe_mem = 1'b1;            exe_wb = 1'b1; end
            OP_ST:   begin exe_mem = 1'b1;            exe_we = 1'b1; end
            OP_BEQZ: begin
                if (op_d == '0) begin
                    exe_npc = pc + imm_pc;
                end
            end
            OP_JMP:  begin exe_npc = imm_pc; end
            OP_HALT: begin exe_halt = 1'b1; end
            default: begin
`ifdef RISC_MC_ILLEGAL_TRAP_EN
                exe_illegal = 1'b1;
`endif
            end
        endcase
    end

    // Instruction register: captured when the fetch handshake completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (state == S_FETCH && bus.imem_ready) begin
            ir <= bus.imem_data;
        end
    end

    // Operand registers: register file read during DECODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            op_d <= '0;
        end else if (state == S_DECODE) begin
            op_a <= regs[rs1];
            op_b <= regs[rs2];
            op_d <= regs[rd];
        end
    end

    // EXECUTE results and memory request fields; load data lands in res_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q    <= '0;
            npc_q    <= '0;
            wb_en_q  <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwe_q    <= 1'b0;
        end else if (state == S_EXECUTE) begin
            res_q    <= exe_res;
            npc_q    <= exe_npc;
            wb_en_q  <= exe_wb;
            maddr_q  <= op_a;
            mwdata_q <= op_d;
            mwe_q    <= exe_we;
        end else if (state == S_MEM && bus.dmem_ready && !mwe_q) begin
            res_q    <= bus.dmem_rdata;
        end
    end

    // PC and register file update in WRITEBACK; writes to R0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == S_WRITEBACK) begin
            pc <= npc_q;
            if (wb_en_q && rd != '0) begin
                regs[rd] <= res_q;
            end
        end
    end

`ifdef RISC_MC_ILLEGAL_TRAP_EN
    // Sticky trap flag: set when an undefined opcode reaches EXECUTE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else if (state == S_EXECUTE && exe_illegal) begin
            trap_q <= 1'b1;
        end
    end

    assign trap = trap_q;
`endif

    // Debug register read port: R0 always reads as zero
    always_comb begin
        dbg_data = '0;
        if (dbg_sel != '0) begin
            dbg_data = regs[dbg_sel];
        end
    end

    // Requests are masked by rst so they drop the moment reset asserts.
    assign bus.imem_req   = imem_req_c & ~rst;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = dmem_req_c & ~rst;
    assign bus.dmem_we    = dmem_req_c & mwe_q & ~rst;
    assign bus.dmem_addr  = maddr_q;
    assign bus.dmem_wdata = mwdata_q;

    assign halted    = (state == S_HALT);
    assign dbg_state = state;

endmodule

// File: tb/tb_risc_mc_core.sv
// Testbench for risc_mc_core: wait-state memory models, directed programs,
// scoreboard queues for fetch addresses and data accesses, and a monitor
// that checks every handshake against those queues.
`timescale 1ns/1ps
module tb_risc_mc_core;
  localparam int DATA_W  = 8;
  localparam int REG_AW  = 4;
  localparam int PC_W    = 6;
  localparam int INSTR_W = 17;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_LDI  = 5'd6;
  localparam logic [4:0] OP_LD   = 5'd7;
  localparam logic [4:0] OP_ST   = 5'd8;
  localparam logic [4:0] OP_BEQZ = 5'd9;
  localparam logic [4:0] OP_JMP  = 5'd10;
  localparam logic [4:0] OP_ILL  = 5'd20;
  localparam logic [4:0] OP_HALT = 5'd31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                halted;
  logic [REG_AW-1:0]   dbg_sel = '0;
  logic [DATA_W-1:0]   dbg_data;
  logic [2:0]          dbg_state;
`ifdef RISC_MC_ILLEGAL_TRAP_EN
  logic                trap;
`endif

  risc_mc_core_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) bus ();

  risc_mc_core #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .halted    (halted),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
`ifdef RISC_MC_ILLEGAL_TRAP_EN
    ,
    .trap      (trap)
`endif
  );

  // ---------------- memory models ----------------
  logic [INSTR_W-1:0] rom [64];
  logic [DATA_W-1:0]  ram [256] = '{default: '0};
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt;
  int dcnt;

  assign bus.imem_ready = bus.imem_req && (icnt >= imem_wait);
  assign bus.imem_data  = rom[bus.imem_addr];
  assign bus.dmem_ready = bus.dmem_req && (dcnt >= dmem_wait);
  assign bus.dmem_rdata = ram[bus.dmem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (bus.imem_req && !bus.imem_ready) ? icnt + 1 : 0;
      dcnt <= (bus.dmem_req && !bus.dmem_ready) ? dcnt + 1 : 0;
      if (bus.dmem_req && bus.dmem_we && bus.dmem_ready)
        ram[bus.dmem_addr] <= bus.dmem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] cycles;
  } dexp_t;

  logic [PC_W-1:0] exp_q[$];
  dexp_t           exp_dmem_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on each completed handshake
  initial begin
    logic            prev_iwait;
    logic [PC_W-1:0] prev_iaddr;
    int              dcyc;
    logic [16:0]     dfirst;
    dexp_t           e;
    prev_iwait = 1'b0;
    prev_iaddr = '0;
    dcyc = 0;
    dfirst = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_iwait = 1'b0;
        dcyc = 0;
      end else begin
        if (bus.imem_req && prev_iwait)
          check("imem_addr_stable", 32'(bus.imem_addr), 32'(prev_iaddr));
        if (bus.imem_req && bus.imem_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL fetch_unexpected: got addr 0x%0h, expected no fetch", bus.imem_addr);
          end else begin
            logic [PC_W-1:0] ea;
            ea = exp_q.pop_front();
            if (bus.imem_addr !== ea) begin
              n_errors++;
              $display("FAIL fetch_addr: got 0x%0h, expected 0x%0h", bus.imem_addr, ea);
            end
          end
        end
        prev_iwait = bus.imem_req && !bus.imem_ready;
        prev_iaddr = bus.imem_addr;

        if (bus.dmem_req) begin
          dcyc++;
          if (dcyc == 1)
            dfirst = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
          else
            check("dmem_stable", 32'({bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}), 32'(dfirst));
          if (bus.dmem_ready) begin
            n_checks++;
            if (exp_dmem_q.size() == 0) begin
              n_errors++;
              $display("FAIL dmem_unexpected: got addr 0x%0h, expected no access", bus.dmem_addr);
            end else begin
              e = exp_dmem_q.pop_front();
              if (bus.dmem_we !== e.we || bus.dmem_addr !== e.addr ||
                  (e.we && bus.dmem_wdata !== e.wdata) || dcyc != int'(e.cycles)) begin
                n_errors++;
                $display("FAIL dmem_access: got we=%0b addr=0x%0h wdata=0x%0h cycles=%0d, expected we=%0b addr=0x%0h wdata=0x%0h cycles=%0d",
                         bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, dcyc, e.we, e.addr, e.wdata, e.cycles);
              end
            end
            dcyc = 0;
          end
        end else begin
          dcyc = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [INSTR_W-1:0] enc_r(input logic [4:0] op, input logic [3:0] rd,
                                               input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  function automatic logic [INSTR_W-1:0] enc_i(input logic [4:0] op, input logic [3:0] rd,
                                               input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = enc_i(OP_HALT, 4'd0, 8'd0);
  endtask

  task automatic push_fetches(input int n, input logic [PC_W-1:0] seq [8]);
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    #1;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic run_until_halt(input int max, output int cyc);
    cyc = 0;
    while (cyc < max && !halted) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!halted) begin
      n_checks++;
      n_errors++;
      $display("FAIL halt_timeout: got halted=0 after %0d cycles, expected halted=1", cyc);
    end
  endtask

  task automatic check_reg(input string name, input logic [3:0] idx, input logic [7:0] exp);
    dbg_sel = idx;
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  task automatic end_test(input string name);
    check({name, "_fetch_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_dmem_drained"}, 32'(exp_dmem_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int cyc;
    logic [PC_W-1:0] seq [8];

    // Test 1: basic ALU program, zero-wait memories, reset values
    clear_rom();
    rom[0] = enc_i(OP_LDI, 4'd1, 8'd5);
    rom[1] = enc_i(OP_LDI, 4'd2, 8'd3);
    rom[2] = enc_r(OP_ADD, 4'd3, 4'd1, 4'd2);
    rom[3] = enc_i(OP_HALT, 4'd0, 8'd0);
    assert_rst();
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(bus.imem_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef RISC_MC_ILLEGAL_TRAP_EN
    check("rst_trap", 32'(trap), 32'd0);
`endif
    seq = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0, 6'd0, 6'd0, 6'd0};
    push_fetches(4, seq);
    release_rst();
    run_until_halt(100, cyc);
    check("t1_halt_cycle", 32'(cyc + 1), 32'd16);
    check("t1_halted", 32'(halted), 32'd1);
    check_reg("t1_r3", 4'd3, 8'd8);
    check_reg("t1_r1", 4'd1, 8'd5);
    end_test("t1");

    // Test 2: ADDI wrap, R0 write discarded
    clear_rom();
    rom[0] = enc_i(OP_LDI, 4'd1, 8'hFF);
    rom[1] = enc_i(OP_ADDI, 4'd1, 8'd2);
    rom[2] = enc_i(OP_LDI, 4'd0, 8'd7);
    rom[3] = enc_r(OP_ADD, 4'd2, 4'd0, 4'd1);
    rom[4] = enc_i(OP_HALT, 4'd0, 8'd0);
    assert_rst();
    seq = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 6'd0, 6'd0};
    push_fetches(5, seq);
    release_rst();
    run_until_halt(100, cyc);
    check_reg("t2_r1_wrap", 4'd1, 8'h01);
    check_reg("t2_r0_dbg", 4'd0, 8'h00);
    check_reg("t2_r2_r0_plus_r1", 4'd2, 8'h01);
    end_test("t2");

    // Test 3: wait-state fetch and data memories, store then load back
    clear_rom();
    rom[0] = enc_i(OP_LDI, 4'd4, 8'hA5);
    rom[1] = enc_i(OP_LDI, 4'd5, 8'h10);
    rom[2] = enc_r(OP_ST, 4'd4, 4'd5, 4'd0);
    rom[3] = enc_r(OP_LD, 4'd6, 4'd5, 4'd0);
    rom[4] = enc_i(OP_HALT, 4'd0, 8'd0);
    assert_rst();
    imem_wait = 3;
    dmem_wait = 2;
    seq = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 6'd0, 6'd0};
    push_fetches(5, seq);
    exp_dmem_q.push_back({1'b1, 8'h10, 8'hA5, 8'd3});
    exp_dmem_q.push_back({1'b0, 8'h10, 8'h00, 8'd3});
    release_rst();
    run_until_halt(200, cyc);
    check("t3_halt_cycle", 32'(cyc + 1), 32'd41);
    check_reg("t3_r6_load", 4'd6, 8'hA5);
    check("t3_ram_10", 32'(ram[8'h10]), 32'hA5);
    end_test("t3");
    imem_wait = 0;
    dmem_wait = 0;

    // Test 4a/4b: BEQZ taken backwards / not taken at PC=5
    clear_rom();
    rom[0] = enc_i(OP_LDI, 4'd6, 8'd0);
    rom[1] = enc_i(OP_JMP, 4'd0, 8'd5);
    rom[3] = enc_i(OP_LDI, 4'd7, 8'h33);
    rom[4] = enc_i(OP_HALT, 4'd0, 8'd0);
    rom[5] = enc_i(OP_BEQZ, 4'd6, 8'hFE);
    rom[6] = enc_i(OP_LDI, 4'd7, 8'h66);
    rom[7] = enc_i(OP_HALT, 4'd0, 8'd0);
    assert_rst();
    seq = '{6'd0, 6'd1, 6'd5, 6'd3, 6'd4, 6'd0, 6'd0, 6'd0};
    push_fetches(5, seq);
    release_rst();
    run_until_halt(100, cyc);
    check_reg("t4a_r7", 4'd7, 8'h33);
    check("t4a_halt_pc", 32'(bus.imem_addr), 32'd4);
    end_test("t4a");

    rom[0] = enc_i(OP_LDI, 4'd6, 8'd1);
    assert_rst();
    seq = '{6'd0, 6'd1, 6'd5, 6'd6, 6'd7, 6'd0, 6'd0, 6'd0};
    push_fetches(5, seq);
    release_rst();
    run_until_halt(100, cyc);
    check_reg("t4b_r7", 4'd7, 8'h66);
    end_test("t4b");

    // Test 4c: JMP 0x3F then BEQZ +1 wraps the PC to 0
    clear_rom();
    rom[0]  = enc_i(OP_BEQZ, 4'd9, 8'd2);
    rom[1]  = enc_i(OP_HALT, 4'd0, 8'd0);
    rom[2]  = enc_i(OP_LDI, 4'd9, 8'd1);
    rom[3]  = enc_i(OP_JMP, 4'd0, 8'h3F);
    rom[63] = enc_i(OP_BEQZ, 4'd0, 8'd1);
    assert_rst();
    seq = '{6'd0, 6'd2, 6'd3, 6'd63, 6'd0, 6'd1, 6'd0, 6'd0};
    push_fetches(6, seq);
    release_rst();
    run_until_halt(100, cyc);
    check_reg("t4c_r9", 4'd9, 8'd1);
    check("t4c_halt_pc", 32'(bus.imem_addr), 32'd1);
    end_test("t4c");

    // Test 5: reset during a waiting store
    clear_rom();
    rom[0] = enc_i(OP_LDI, 4'd4, 8'h5A);
    rom[1] = enc_i(OP_LDI, 4'd5, 8'h20);
    rom[2] = enc_r(OP_ST, 4'd4, 4'd5, 4'd0);
    rom[3] = enc_i(OP_HALT, 4'd0, 8'd0);
    assert_rst();
    dmem_wait = 10;
    seq = '{6'd0, 6'd1, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    push_fetches(3, seq);
    release_rst();
    cyc = 0;
    while (cyc < 50 && !bus.dmem_req) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t5_req_seen", 32'(bus.dmem_req), 32'd1);
    @(posedge clk);
    #2;
    check("t5_req_held", 32'(bus.dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_req_dropped", 32'(bus.dmem_req), 32'd0);
    check("t5_we_dropped", 32'(bus.dmem_we), 32'd0);
    check("t5_pc_zero", 32'(bus.imem_addr), 32'd0);
    check("t5_state_fetch", 32'(dbg_state), 32'd0);
    check_reg("t5_r4_zero", 4'd4, 8'd0);
    check_reg("t5_r5_zero", 4'd5, 8'd0);
    check("t5_no_write", 32'(ram[8'h20]), 32'd0);
    end_test("t5a");
    dmem_wait = 0;
    seq = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0, 6'd0, 6'd0, 6'd0};
    push_fetches(4, seq);
    exp_dmem_q.push_back({1'b1, 8'h20, 8'h5A, 8'd1});
    release_rst();
    run_until_halt(100, cyc);
    check("t5_ram_20", 32'(ram[8'h20]), 32'h5A);
    end_test("t5b");

    // Test 6: undefined opcode 20 at PC=2
    clear_rom();
    rom[0] = enc_i(OP_LDI, 4'd1, 8'd1);
    rom[1] = enc_i(OP_LDI, 4'd2, 8'd2);
    rom[2] = enc_i(OP_ILL, 4'd0, 8'd0);
    rom[3] = enc_i(OP_LDI, 4'd3, 8'd3);
    rom[4] = enc_i(OP_HALT, 4'd0, 8'd0);
    assert_rst();
`ifdef RISC_MC_ILLEGAL_TRAP_EN
    seq = '{6'd0, 6'd1, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    push_fetches(3, seq);
    release_rst();
    run_until_halt(100, cyc);
    check("t6_trap", 32'(trap), 32'd1);
    check("t6_halted", 32'(halted), 32'd1);
    check("t6_pc_fault", 32'(bus.imem_addr), 32'd2);
    check_reg("t6_r3_unwritten", 4'd3, 8'd0);
`else
    seq = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 6'd0, 6'd0};
    push_fetches(5, seq);
    release_rst();
    run_until_halt(100, cyc);
    check("t6_halt_cycle", 32'(cyc + 1), 32'd20);
    check("t6_pc_halt", 32'(bus.imem_addr), 32'd4);
    check_reg("t6_r3", 4'd3, 8'd3);
`endif
    check_reg("t6_r2", 4'd2, 8'd2);
    end_test("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
